lb_sequencer: RTL

- Sequences the four sprite line buffers, organised as two ping-pong pairs (A, B), each split into even-pixel and odd-pixel buffers.
- On each scanline, one pair is the render side: the sprite renderer writes pixels into it.
- The other pair is the display side: each pixel is read out to the palette path, then cleared to backdrop.
- Sits between the sprite renderer / video timing and the four line buffer instances, and drives their address, write-strobe and clear controls.

---
 rtl/lb_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/lb_sequencer.sv
// Ping-pong sprite line buffer sequencer: render writes one pair, display reads then clears the other.
// Optional macro LB_HFLIP_EN adds the HFLIP input for descending display order.
module lb_sequencer #(
  parameter int LB_DEPTH    = 192,
  parameter int LINE_PIXELS = 320
) (
  input  logic       CK,
  input  logic       nRESET,
  input  logic       PIX_EN,
  input  logic       LINE_START,
  input  logic       REN_LOAD,
  input  logic [8:0] REN_X,
  input  logic       REN_PIX,
  input  logic       REN_OPAQUE,
`ifdef LB_HFLIP_EN
  input  logic       HFLIP,
`endif
  output logic       REN_READY,
  output logic       SEL,
  output logic [7:0] LB_ADDR_A,
  output logic [7:0] LB_ADDR_B,
  output logic [3:0] LB_WE_N,
  output logic [3:0] LB_CLEARING,
  output logic       DISP_ODD,
  output logic       OVERRUN,
  output logic [1:0] fsm_state
);

  localparam logic [8:0] X_LIMIT = 9'(2 * LB_DEPTH);
  localparam logic [8:0] LP      = 9'(LINE_PIXELS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    SWAP   = 2'd2
  } state_t;

  state_t     st;
  logic [8:0] wx;
  logic [8:0] dx;
  logic       clr_pend;
  logic [1:0] clr_idx;
  logic       pix_en_q;
`ifdef LB_HFLIP_EN
  logic       hflip_q;
`endif

  logic       pix_ok;
  logic [8:0] x_eff;
  logic [8:0] x_inc;
  logic       x_in_range;
  logic [8:0] dx_rd;
  logic       disp_go;

  assign fsm_state = st;

  // REN_PIX is taken on any cycle REN_READY is high; there is no backpressure
  // within a line, the renderer simply stops presenting pixels while REN_READY is low.
  always_comb begin
    pix_ok     = PIX_EN && !pix_en_q;
    x_eff      = REN_LOAD ? REN_X : wx;
    x_inc      = (x_eff == 9'd511) ? 9'd511 : x_eff + 9'd1;
    x_in_range = x_eff < X_LIMIT;
    dx_rd      = dx;
`ifdef LB_HFLIP_EN
    if (hflip_q) dx_rd = LP - 9'd1 - dx;
`endif
    disp_go    = pix_ok && (dx < LP) && (st != SWAP);
  end

  always_ff @(posedge CK) begin
    if (!nRESET) begin
      st          <= IDLE;
      wx          <= 9'd0;
      dx          <= LP;
      clr_pend    <= 1'b0;
      clr_idx     <= 2'd0;
      pix_en_q    <= 1'b0;
`ifdef LB_HFLIP_EN
      hflip_q     <= 1'b0;
`endif
      REN_READY   <= 1'b0;
      SEL         <= 1'b0;
      LB_ADDR_A   <= 8'd0;
      LB_ADDR_B   <= 8'd0;
      LB_WE_N     <= 4'hF;
      LB_CLEARING <= 4'h0;
      DISP_ODD    <= 1'b0;
      OVERRUN     <= 1'b0;
    end else begin
      pix_en_q    <= PIX_EN;
      LB_WE_N     <= 4'hF;
      LB_CLEARING <= 4'h0;

      if (PIX_EN && pix_en_q) OVERRUN <= 1'b1;

      // Clear phase: clr_idx was latched at read time, so it still names the
      // old display pair when this lands on the SWAP edge.
      if (clr_pend) begin
        LB_WE_N[clr_idx]     <= 1'b0;
        LB_CLEARING[clr_idx] <= 1'b1;
        clr_pend             <= 1'b0;
        dx                   <= dx + 9'd1;
      end

      if (disp_go) begin
        if (SEL) LB_ADDR_A <= dx_rd[8:1];
        else     LB_ADDR_B <= dx_rd[8:1];
        DISP_ODD <= dx_rd[0];
        clr_pend <= 1'b1;
        clr_idx  <= {~SEL, dx_rd[0]};
      end

      if (st == ACTIVE) begin
        if (REN_PIX) begin
          wx <= x_inc;
          if (x_in_range) begin
            if (REN_OPAQUE) begin
              if (SEL) LB_ADDR_B <= x_eff[8:1];
              else     LB_ADDR_A <= x_eff[8:1];
              LB_WE_N[{SEL, x_eff[0]}] <= 1'b0;
            end
          end else begin
            OVERRUN <= 1'b1;
          end
        end else if (REN_LOAD) begin
          wx <= REN_X;
        end
      end

      case (st)
        IDLE, ACTIVE: begin
          if (LINE_START && pix_ok) begin
            st        <= SWAP;
            REN_READY <= 1'b0;
          end
        end
        SWAP: begin
          st        <= ACTIVE;
          REN_READY <= 1'b1;
          SEL       <= ~SEL;
          wx        <= 9'd0;
          dx        <= 9'd0;
`ifdef LB_HFLIP_EN
          hflip_q   <= HFLIP;
`endif
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
